// File: rtl/cpu6502_operand_fetch_if.sv
// Bus bundle for the 6502 ALU-group operand-fetch sequencer.
//   master : the requester/memory side. It drives start, opcode, pc, x_reg,
//            y_reg and mem_rdata, and it observes the bus and result outputs.
//   slave  : the sequencer itself. It drives mem_addr, mem_rd, busy, done,
//            operation, operand, ea, next_pc and illegal.
interface cpu6502_operand_fetch_if;
    logic        start;
    logic [7:0]  opcode;
    logic [15:0] pc;
    logic [7:0]  x_reg;
    logic [7:0]  y_reg;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [4:0]  operation;
    logic [7:0]  operand;
    logic [15:0] ea;
    logic [15:0] next_pc;
    logic        illegal;

    modport master (
        output start, opcode, pc, x_reg, y_reg, mem_rdata,
        input  mem_addr, mem_rd, busy, done, operation, operand, ea, next_pc, illegal
    );

    modport slave (
        input  start, opcode, pc, x_reg, y_reg, mem_rdata,
        output mem_addr, mem_rd, busy, done, operation, operand, ea, next_pc, illegal
    );
endinterface

// File: rtl/cpu6502_operand_fetch.sv
// Operand-fetch sequencer for the 6502 ALU-group opcodes (cc = 01).
// It walks the addressing mode over the memory bus with 6502-accurate cycles,
// including dummy reads and page-cross penalties. It then presents the ALU
// operation field, the operand byte, the effective address and the next PC.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request (start/opcode/pc/x_reg/y_reg), memory bus
//                (mem_addr/mem_rd/mem_rdata) and results (busy/done/operation/
//                operand/ea/next_pc/illegal)
module cpu6502_operand_fetch (
    input  logic                          clk,
    input  logic                          reset,
    cpu6502_operand_fetch_if.slave        bus
);

    typedef enum logic [3:0] {
        IDLE, OPER0, OPER1, DUMMY, PTRLO, PTRHI, FIXUP, DATA, DONE
    } state_t;

    typedef enum logic [2:0] {
        M_IZX = 3'b000, M_ZP  = 3'b001, M_IMM = 3'b010, M_ABS = 3'b011,
        M_IZY = 3'b100, M_ZPX = 3'b101, M_ABY = 3'b110, M_ABX = 3'b111
    } mode_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] npc_q, npc_d;
    logic [7:0]  zp_q, zp_d;
    logic [7:0]  adl_q, adl_d;
    logic [15:0] eff_q, eff_d;

    logic [15:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  operation_q, operation_d;
    logic [7:0]  operand_q, operand_d;
    logic [15:0] ea_q, ea_d;
    logic [15:0] next_pc_q, next_pc_d;
    logic        illegal_q, illegal_d;

    mode_t       mode;
    logic        is_sta;
    logic [7:0]  idx;
    logic [8:0]  idx_sum;
    logic [15:0] idx_ea;
    logic [7:0]  zx;
    logic [7:0]  zp_inc;
    logic        req_bad;
    logic        req_long;

    logic        finish;
    logic [15:0] fin_ea;
    logic        to_data;
    logic [15:0] data_addr;

    assign mode     = mode_t'(op_q[4:2]);
    assign is_sta   = (op_q[7:5] == 3'b100);
    assign idx      = (mode == M_ABX) ? bus.x_reg : bus.y_reg;
    // adl_q holds ADL for abs,X/abs,Y and the pointer low byte for (zp),Y;
    // mem_rdata is the high byte arriving in the current slot.
    assign idx_sum  = {1'b0, adl_q} + {1'b0, idx};
    assign idx_ea   = {bus.mem_rdata, adl_q} + {8'h00, idx};
    assign zx       = zp_q + bus.x_reg;
    assign zp_inc   = zp_q + 8'd1;
    assign req_bad  = (bus.opcode[1:0] != 2'b01) || (bus.opcode == 8'h89);
    assign req_long = (bus.opcode[4:2] == 3'b011) || (bus.opcode[4:3] == 2'b11);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        zp_d        = zp_q;
        adl_d       = adl_q;
        eff_d       = eff_q;
        addr_d      = '0;
        rd_d        = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        operation_d = operation_q;
        operand_d   = operand_q;
        ea_d        = ea_q;
        next_pc_d   = next_pc_q;
        illegal_d   = illegal_q;
        finish      = 1'b0;
        fin_ea      = '0;
        to_data     = 1'b0;
        data_addr   = '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_d  = bus.opcode;
                    pc_d  = bus.pc;
                    npc_d = req_long ? bus.pc + 16'd2 : bus.pc + 16'd1;
                    if (req_bad) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        operation_d = {bus.opcode[7:5], bus.opcode[1:0]};
                        operand_d   = '0;
                        ea_d        = '0;
                        next_pc_d   = '0;
                        illegal_d   = 1'b1;
                    end else begin
                        state_d = OPER0;
                        addr_d  = bus.pc;
                        rd_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            OPER0: begin
                busy_d = 1'b1;
                rd_d   = 1'b1;
                zp_d   = bus.mem_rdata;
                adl_d  = bus.mem_rdata;
                case (mode)
                    M_IMM: begin
                        finish = 1'b1;
                        fin_ea = pc_q;
                    end
                    M_ZP: begin
                        to_data   = 1'b1;
                        data_addr = {8'h00, bus.mem_rdata};
                    end
                    M_ABS, M_ABX, M_ABY: begin
                        state_d = OPER1;
                        addr_d  = pc_q + 16'd1;
                    end
                    M_ZPX, M_IZX: begin
                        state_d = DUMMY;
                        addr_d  = {8'h00, bus.mem_rdata};
                    end
                    M_IZY: begin
                        state_d = PTRLO;
                        addr_d  = {8'h00, bus.mem_rdata};
                    end
                endcase
            end
            // The high address byte arrives here for both absolute (OPER1) and
            // pointer (PTRHI) modes. Indexed modes share the page-cross handling.
            OPER1, PTRHI: begin
                busy_d = 1'b1;
                rd_d   = 1'b1;
                if (mode == M_ABS || mode == M_IZX) begin
                    to_data   = 1'b1;
                    data_addr = {bus.mem_rdata, adl_q};
                end else if (idx_sum[8] || is_sta) begin
                    state_d = FIXUP;
                    addr_d  = {bus.mem_rdata, idx_sum[7:0]};
                    eff_d   = idx_ea;
                end else begin
                    to_data   = 1'b1;
                    data_addr = idx_ea;
                end
            end
            DUMMY: begin
                busy_d = 1'b1;
                rd_d   = 1'b1;
                zp_d   = zx;
                if (mode == M_ZPX) begin
                    to_data   = 1'b1;
                    data_addr = {8'h00, zx};
                end else begin
                    state_d = PTRLO;
                    addr_d  = {8'h00, zx};
                end
            end
            PTRLO: begin
                busy_d  = 1'b1;
                rd_d    = 1'b1;
                adl_d   = bus.mem_rdata;
                state_d = PTRHI;
                addr_d  = {8'h00, zp_inc};
            end
            FIXUP: begin
                busy_d    = 1'b1;
                rd_d      = 1'b1;
                to_data   = 1'b1;
                data_addr = eff_q;
            end
            DATA: begin
                finish = 1'b1;
                fin_ea = eff_q;
            end
            default: state_d = IDLE;
        endcase

        // The final slot is a read except for STA, which only occupies the cycle.
        if (to_data) begin
            state_d = DATA;
            addr_d  = data_addr;
            rd_d    = ~is_sta;
            eff_d   = data_addr;
        end

        if (finish) begin
            state_d     = DONE;
            addr_d      = '0;
            rd_d        = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            operation_d = {op_q[7:5], op_q[1:0]};
            operand_d   = is_sta ? 8'h00 : bus.mem_rdata;
            ea_d        = fin_ea;
            next_pc_d   = npc_q;
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            pc_q        <= '0;
            npc_q       <= '0;
            zp_q        <= '0;
            adl_q       <= '0;
            eff_q       <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            operation_q <= '0;
            operand_q   <= '0;
            ea_q        <= '0;
            next_pc_q   <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            zp_q        <= zp_d;
            adl_q       <= adl_d;
            eff_q       <= eff_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            operation_q <= operation_d;
            operand_q   <= operand_d;
            ea_q        <= ea_d;
            next_pc_q   <= next_pc_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = rd_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.operation = operation_q;
    assign bus.operand   = operand_q;
    assign bus.ea        = ea_q;
    assign bus.next_pc   = next_pc_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: doc/cpu6502_operand_fetch.md
# cpu6502_operand_fetch

Operand-fetch sequencer for the 6502 ALU-group instructions (opcode[1:0] = 01: ORA, AND, EOR, ADC, STA, LDA, CMP, SBC). It sits directly upstream of the 6502 ALU. Given a decoded opcode and the address of its first operand byte, it walks the addressing mode over the memory bus with 6502-accurate bus cycles, including dummy reads and page-cross penalties. It then hands the ALU a 5-bit operation code and an 8-bit operand, together with the effective address and the next PC.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- opcode  in  8  instruction opcode; sampled with start.
- pc  in  16  address of the byte after the opcode; sampled with start.
- x_reg  in  8  X index; must be stable while busy=1.
- y_reg  in  8  Y index; must be stable while busy=1.
- mem_addr  out  16  bus address, registered.
- mem_rd  out  1  read strobe, registered.
- mem_rdata  in  8  read data; combinational (same-cycle) memory; sampled at the end of each mem_rd cycle.
- busy  out  1  high during bus slots.
- done  out  1  one-cycle pulse; result outputs are valid this cycle.
- operation  out  5  {opcode[7:5], opcode[1:0]}; the ALU operation field.
- operand  out  8  fetched operand byte.
- ea  out  16  effective address (pc for immediate).
- next_pc  out  16  pc + operand length, 16-bit wrap.
- illegal  out  1  qualifies done; the opcode was not handled.

## Operation
- States: IDLE, OPER0, OPER1, DUMMY, PTRLO, PTRHI, FIXUP, DATA, DONE.
- Every state except IDLE and DONE is exactly one bus slot, with mem_rd=1 unless stated otherwise.
- Slot sequences by addressing mode (bbb = opcode[4:2]), where ADL/ADH are the fetched address low/high bytes:
  - 010 immediate: pc. Operand is the byte read at pc.
  - 001 zp: pc, then {00,zp}.
  - 011 abs: pc, pc+1, then {ADH,ADL}.
  - 101 zp,X: pc, dummy {00,zp}, then {00,(zp+X)[7:0]}.
  - 110 abs,Y / 111 abs,X: pc, pc+1. If ADL+idx carries, a dummy slot at {ADH,(ADL+idx)[7:0]} follows. Final slot at {ADH,ADL}+idx.
  - 000 (zp,X): pc, dummy {00,zp}, ptr lo at {00,(zp+X)[7:0]}, ptr hi at {00,(zp+X+1)[7:0]} (zero-page wrap), then ea.
  - 100 (zp),Y: pc, ptr lo {00,zp}, ptr hi {00,(zp+1)[7:0]}. A dummy slot follows on page cross. Final slot at ptr+Y.
- STA (aaa=100):
  - The dummy slot is always taken for abs,X, abs,Y and (zp),Y, whether or not the page crosses.
  - The final ea slot still occupies a cycle, but with mem_rd=0.
  - operand=00.
- illegal:
  - Raised when opcode[1:0]≠01, or for STA immediate (0x89).
  - No bus slots are issued; done and illegal are raised in cycle 1.
  - operand, ea and next_pc = 0.
- next_pc:
  - pc+2 for abs, abs,X and abs,Y.
  - pc+1 for all other modes.
  - FFFF wraps to 0000/0001.
- ea arithmetic is 16-bit modulo; abs,X at FFFF with X=01 gives 0000.

## Timing
- Cycle 0 is the cycle in which start=1 and busy=0; the request is captured at the end of cycle 0.
- Slots occupy cycles 1..R, with busy=1 throughout.
- done=1 in cycle R+1, with busy=0 and mem_rd=0.
- R per mode, loads and arithmetic:
  - imm: 1
  - zp: 2
  - abs: 3
  - zp,X: 3
  - abs,X / abs,Y: 3, or 4 on page cross
  - (zp,X): 5
  - (zp),Y: 4, or 5 on page cross
- R for STA: abs,X / abs,Y = 4; (zp),Y = 5.
- A start arriving in the done cycle is accepted, giving back-to-back operation with no gap.
- A start arriving while busy=1 is ignored.
- operation, operand, ea, next_pc and illegal hold their values until the next done.
- Reset values: every output is 0, and the FSM is in IDLE.
- Reset mid-sequence: the next cycle shows IDLE with mem_rd=0, busy=0 and done=0. No done is emitted for the aborted request.

## Test plan
- Immediate: ADC #$42 (0x69), pc=0200, mem[0200]=42.
  - Expect one read at 0200 in cycle 1.
  - done in cycle 2 with operand=42, operation=01101, next_pc=0201, ea=0200.
- Absolute indexed: LDA $1234,X (0xBD), pc=0200.
  - X=10: reads 0200, 0201, 1244; done in cycle 4.
  - X=D0: reads 0200, 0201, 1204 (dummy), 1304; done in cycle 5 with ea=1304.
- Indexed indirect: ADC ($FE,X) (0x61), zp=FE, X=01, mem[00FF]=00, mem[0000]=30.
  - Expect reads pc, 00FE, 00FF, 0000, 3000.
  - done in cycle 6 with ea=3000.
- Indirect indexed with page cross: LDA ($10),Y (0xB1), mem[0010]=F0, mem[0011]=20, Y=20.
  - Expect reads pc, 0010, 0011, 2010 (dummy), 2110.
  - done in cycle 6.
- STA abs,Y (0x99), no page cross.
  - Dummy slot still occurs, and the final slot has mem_rd=0.
  - done in cycle 5 with operand=00.
- Control cases:
  - Opcode 0x89 gives done and illegal in cycle 1 with no reads.
  - A start pulse while busy=1 is ignored.
  - reset in cycle 2 of an abs fetch leaves all outputs 0 from cycle 3 and never produces done.
  - start in the done cycle begins the next fetch in the following cycle.
